// File: rtl/fp32_mul_sequencer_if.sv
// fp32_mul_sequencer_if: handshake and core-facing signals of the FP32 multiply sequencer
//   in_*   : operand pair valid/ready input with user tag
//   mul_*  : start/done protocol toward the multiplier32FP core
//   out_*  : result FIFO head with valid/ready
//   sticky_o, clear_sticky_i, busy_o : status
//   master : sequencer side; slave : environment side
interface fp32_mul_sequencer_if #(
   parameter int TAG_W = 4
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      in_a_i;
   logic [31:0]      in_b_i;
   logic [TAG_W-1:0] in_tag_i;
   logic             mul_start_o;
   logic [31:0]      mul_a_o;
   logic [31:0]      mul_b_o;
   logic [31:0]      mul_product_i;
   logic             mul_done_i;
   logic             mul_nan_i;
   logic             mul_inf_i;
   logic             mul_ovf_i;
   logic             mul_udf_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [31:0]      out_result_o;
   logic [4:0]       out_flags_o;
   logic [TAG_W-1:0] out_tag_o;
   logic [4:0]       sticky_o;
   logic             clear_sticky_i;
   logic             busy_o;
   modport master (
      input  in_valid_i, in_a_i, in_b_i, in_tag_i,
      input  mul_product_i, mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_udf_i,
      input  out_ready_i, clear_sticky_i,
      output in_ready_o, mul_start_o, mul_a_o, mul_b_o,
      output out_valid_o, out_result_o, out_flags_o, out_tag_o, sticky_o, busy_o
   );
   modport slave (
      output in_valid_i, in_a_i, in_b_i, in_tag_i,
      output mul_product_i, mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_udf_i,
      output out_ready_i, clear_sticky_i,
      input  in_ready_o, mul_start_o, mul_a_o, mul_b_o,
      input  out_valid_o, out_result_o, out_flags_o, out_tag_o, sticky_o, busy_o
   );
endinterface

// File: rtl/fp32_mul_sequencer.sv
// fp32_mul_sequencer: issues FP32 operand pairs to the multiplier core and queues tagged results
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fp32_mul_sequencer_if.master (operand input, core start/done, result FIFO, status)
// Optional watchdog for a hung core: define FP32_SEQ_TIMEOUT_EN.
module fp32_mul_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4,
   parameter int TIMEOUT    = 15
) (
   input logic                  clk,
   input logic                  rst_n,
   fp32_mul_sequencer_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = TAG_W + 5 + 32;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 4) begin : g_bad_cfg
      $error("fp32_mul_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 4");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state, state_n;
   logic             ready_en;
   logic             accept;
   logic             push;
   logic             pop;
   logic             timeout;
   logic [31:0]      a_q, b_q;
   logic [TAG_W-1:0] tag_q;
   logic [3:0]       acc;
   logic [3:0]       cur_flags;
   logic [4:0]       push_flags;
   logic [31:0]      push_result;
   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [EW-1:0]    head;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic [4:0]       sticky;

   assign cur_flags = {bus.mul_udf_i, bus.mul_ovf_i, bus.mul_inf_i, bus.mul_nan_i};

`ifdef FP32_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] wd_cnt;
   assign timeout = (state == WAIT) && !bus.mul_done_i && (wd_cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_cnt <= '0;
      else if (state == ISSUE) wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + CW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // ready_en keeps in_ready_o low during reset and until the first edge after release
   assign bus.in_ready_o = ready_en && (state == IDLE) && (count != (PW + 1)'(FIFO_DEPTH));
   assign accept         = bus.in_valid_i && bus.in_ready_o;
   assign pop            = bus.out_valid_o && bus.out_ready_i;

   // a timeout entry carries only what accumulated before it fired
   assign push_flags  = bus.mul_done_i ? {1'b0, acc | cur_flags} : {1'b1, acc};
   assign push_result = bus.mul_done_i ? bus.mul_product_i : 32'h7FC0_0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      push    = 1'b0;
      case (state)
         IDLE:  state_n = accept ? ISSUE : IDLE;
         ISSUE: state_n = WAIT;
         WAIT: begin
            push    = bus.mul_done_i || timeout;
            state_n = push ? IDLE : WAIT;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         tag_q    <= '0;
         acc      <= '0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            a_q   <= bus.in_a_i;
            b_q   <= bus.in_b_i;
            tag_q <= bus.in_tag_i;
            acc   <= '0;
         end else if (state == WAIT) begin
            acc <= acc | cur_flags;
         end
      end
   end

   // only one operation is in flight and in_ready_o checks for a free slot,
   // so a push never meets a full FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         sticky <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {tag_q, push_flags, push_result};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count  <= count + (PW + 1)'(push) - (PW + 1)'(pop);
         sticky <= (bus.clear_sticky_i ? 5'b0 : sticky) | (push ? push_flags : 5'b0);
      end
   end

   assign head             = mem[rd_ptr];
   assign bus.out_valid_o  = count != '0;
   assign bus.out_tag_o    = head[EW-1 -: TAG_W];
   assign bus.out_flags_o  = head[36:32];
   assign bus.out_result_o = head[31:0];
   assign bus.sticky_o     = sticky;
   assign bus.mul_start_o  = state == ISSUE;
   assign bus.mul_a_o      = a_q;
   assign bus.mul_b_o      = b_q;
   assign bus.busy_o       = state != IDLE;
endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// tb_fp32_mul_sequencer: directed self-checking bench with a scripted multiplier core
module tb_fp32_mul_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   fp32_mul_sequencer_if #(.TAG_W(4)) bus ();

   fp32_mul_sequencer #(.FIFO_DEPTH(4), .TAG_W(4), .TIMEOUT(15)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive a pair from a negedge and return at the negedge of cycle 1 (ISSUE)
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      int n = 0;
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = a;
      bus.in_b_i     = b;
      bus.in_tag_i   = tag;
      while (!bus.in_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", bus.in_ready_o, 1);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
   endtask

   // core model: flags in cycle lat, done in cycle lat+1; returns at the negedge of cycle lat+2
   task automatic core(input logic [31:0] a, input logic [31:0] prod, input logic [3:0] fl,
                       input int lat, input logic clr);
      chk("start_pulse", bus.mul_start_o, 1);
      chk("busy_in_op", bus.busy_o, 1);
      chk("ready_in_op", bus.in_ready_o, 0);
      for (int i = 2; i <= lat + 1; i++) begin
         @(negedge clk);
         if (i == 2) begin
            chk("start_one_cycle", bus.mul_start_o, 0);
            chk("operand_hold", bus.mul_a_o, a);
         end
         {bus.mul_udf_i, bus.mul_ovf_i, bus.mul_inf_i, bus.mul_nan_i} = (i == lat) ? fl : 4'b0;
         bus.mul_done_i     = (i == lat + 1);
         bus.clear_sticky_i = clr && (i == lat + 1);
         bus.mul_product_i  = prod;
      end
      @(negedge clk);
      bus.mul_done_i     = 1'b0;
      bus.clear_sticky_i = 1'b0;
      chk("idle_after_done", bus.busy_o, 0);
   endtask

   task automatic head(input string tag, input logic [31:0] res, input logic [4:0] fl,
                       input logic [3:0] t);
      chk({tag, "_valid"}, bus.out_valid_o, 1);
      chk({tag, "_result"}, bus.out_result_o, res);
      chk({tag, "_flags"}, bus.out_flags_o, fl);
      chk({tag, "_tag"}, bus.out_tag_o, t);
   endtask

   logic [31:0] bp_b [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

   initial begin
      bus.in_valid_i     = 1'b0;
      bus.in_a_i         = '0;
      bus.in_b_i         = '0;
      bus.in_tag_i       = '0;
      bus.mul_product_i  = '0;
      bus.mul_done_i     = 1'b0;
      bus.mul_nan_i      = 1'b0;
      bus.mul_inf_i      = 1'b0;
      bus.mul_ovf_i      = 1'b0;
      bus.mul_udf_i      = 1'b0;
      bus.out_ready_i    = 1'b1;
      bus.clear_sticky_i = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", bus.in_ready_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_sticky", bus.sticky_o, 0);
      chk("rst_start", bus.mul_start_o, 0);
      chk("rst_mul_a", bus.mul_a_o, 0);
      chk("rst_out_result", bus.out_result_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready_o, 1);

      // normal multiply 2.0 * 3.0
      send(32'h4000_0000, 32'h4040_0000, 4'd3);
      chk("mul_b_latched", bus.mul_b_o, 32'h4040_0000);
      core(32'h4000_0000, 32'h40C0_0000, 4'b0000, 3, 1'b0);
      head("normal", 32'h40C0_0000, 5'b00000, 4'd3);
      chk("normal_sticky", bus.sticky_o, 0);

      // NaN operand: one cycle shorter
      send(32'h7FC0_0000, 32'h3F80_0000, 4'd5);
      core(32'h7FC0_0000, 32'h0000_0000, 4'b0001, 2, 1'b0);
      head("nan", 32'h0000_0000, 5'b00001, 4'd5);
      chk("nan_sticky", bus.sticky_o, 5'b00001);

      // overflow, then inf with sticky clear on its push cycle
      send(32'h7F00_0000, 32'h4000_0000, 4'd6);
      core(32'h7F00_0000, 32'h7F80_0000, 4'b0100, 3, 1'b0);
      head("ovf", 32'h7F80_0000, 5'b00100, 4'd6);
      chk("ovf_sticky", bus.sticky_o, 5'b00101);
      send(32'h7F80_0000, 32'h4000_0000, 4'd2);
      core(32'h7F80_0000, 32'h7F80_0000, 4'b0010, 3, 1'b1);
      head("inf", 32'h7F80_0000, 5'b00010, 4'd2);
      chk("clear_sticky_set_wins", bus.sticky_o, 5'b00010);
      @(negedge clk);
      chk("inf_popped", bus.out_valid_o, 0);

      // backpressure: fill the FIFO, hold a fifth pair, single pop, drain in order
      bus.out_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send(32'h3F80_0000, bp_b[k], 4'(8 + k));
         core(32'h3F80_0000, bp_b[k], 4'b0000, 3, 1'b0);
      end
      chk("full_in_ready", bus.in_ready_o, 0);
      head("full_head", 32'h4000_0000, 5'b00000, 4'd8);
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = 32'h3F80_0000;
      bus.in_b_i     = bp_b[4];
      bus.in_tag_i   = 4'd12;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("held_in_ready", bus.in_ready_o, 0);
         chk("held_busy", bus.busy_o, 0);
      end
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      chk("after_pop_in_ready", bus.in_ready_o, 1);
      head("after_pop_head", 32'h4040_0000, 5'b00000, 4'd9);
      send(32'h3F80_0000, bp_b[4], 4'd12);
      core(32'h3F80_0000, bp_b[4], 4'b0000, 3, 1'b0);
      bus.out_ready_i = 1'b1;
      for (int k = 1; k < 5; k++) begin
         head("drain", bp_b[k], 5'b00000, 4'(8 + k));
         @(negedge clk);
      end
      chk("drained", bus.out_valid_o, 0);
      bus.out_ready_i = 1'b0;

`ifdef FP32_SEQ_TIMEOUT_EN
      begin
         int n = 0;
         send(32'h3F80_0000, 32'h4000_0000, 4'd7);
         chk("wd_start", bus.mul_start_o, 1);
         while (!bus.out_valid_o && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("wd_latency", 64'(n), 64'd16);
         head("wd", 32'h7FC0_0000, 5'b10000, 4'd7);
         chk("wd_busy", bus.busy_o, 0);
         chk("wd_in_ready", bus.in_ready_o, 1);
         chk("wd_sticky", bus.sticky_o, 5'b10010);
         bus.mul_done_i = 1'b1;
         @(negedge clk);
         bus.mul_done_i  = 1'b0;
         bus.out_ready_i = 1'b1;
         @(negedge clk);
         bus.out_ready_i = 1'b0;
         chk("late_done_ignored", bus.out_valid_o, 0);
         send(32'h4000_0000, 32'h4000_0000, 4'd4);
         core(32'h4000_0000, 32'h4080_0000, 4'b0000, 3, 1'b0);
         head("after_wd", 32'h4080_0000, 5'b00000, 4'd4);
         bus.out_ready_i = 1'b1;
         @(negedge clk);
         bus.out_ready_i = 1'b0;
      end
`endif

      // reset mid-WAIT with a queued entry and non-zero sticky
      send(32'h7F00_0000, 32'h4000_0000, 4'd1);
      core(32'h7F00_0000, 32'h7F80_0000, 4'b0100, 3, 1'b0);
      chk("pre_rst_valid", bus.out_valid_o, 1);
      send(32'h4000_0000, 32'h4040_0000, 4'd2);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", bus.busy_o, 0);
      chk("midrst_out_valid", bus.out_valid_o, 0);
      chk("midrst_sticky", bus.sticky_o, 0);
      chk("midrst_in_ready", bus.in_ready_o, 0);
      chk("midrst_mul_a", bus.mul_a_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", bus.in_ready_o, 1);
      chk("release_no_stale", bus.out_valid_o, 0);
      chk("release_busy", bus.busy_o, 0);
      bus.out_ready_i = 1'b1;
      send(32'h4000_0000, 32'h4040_0000, 4'd14);
      core(32'h4000_0000, 32'h40C0_0000, 4'b0000, 3, 1'b0);
      head("post_rst_op", 32'h40C0_0000, 5'b00000, 4'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
